// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One bit per cycle: shift-add multiply, restoring divide on operand magnitudes.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } stateT;

    stateT            state;
    logic [CW-1:0]    count;
    logic [2:0]       opReg;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] operand;
    logic [DW-1:0]    accum;
    logic             negQ;
    logic             negR;
    logic             bZero;

    // Decode of the incoming request, used only at the accepting edge
    logic             sgnOp;
    logic             divOp;
    logic             aNeg;
    logic             bNeg;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;

    always_comb begin
        sgnOp = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
        divOp = (Op == OP_DIV) || (Op == OP_DIVU);
        aNeg  = sgnOp && A[WIDTH-1];
        bNeg  = sgnOp && B[WIDTH-1];
        absA  = aNeg ? -A : A;
        absB  = bNeg ? -B : B;
    end

    // One iteration; accum holds {partial, multiplier} or {remainder, dividend/quotient}
    logic             runDiv;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH:0]   divDiff;
    logic             divGe;
    logic [DW-1:0]    stepNext;

    always_comb begin
        runDiv   = (opReg == OP_DIV) || (opReg == OP_DIVU);
        mulSum   = {1'b0, accum[DW-1:WIDTH]} + (accum[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        divShift = accum[DW-1:WIDTH-1];
        divDiff  = divShift - {1'b0, operand};
        divGe    = ~divDiff[WIDTH];
        if (runDiv) begin
            stepNext = {(divGe ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0]),
                        accum[WIDTH-2:0], divGe};
        end else begin
            stepNext = {mulSum, accum[WIDTH-1:1]};
        end
    end

    // Sign correction, accumulate and divide-by-zero override for the final edge
    logic [DW-1:0]    product;
    logic [DW-1:0]    hiLo;
    logic [DW-1:0]    mulResult;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] finalHi;
    logic [WIDTH-1:0] finalLo;

    always_comb begin
        product   = negQ ? -stepNext : stepNext;
        hiLo      = {HI, LO};
        quot      = negQ ? -stepNext[WIDTH-1:0] : stepNext[WIDTH-1:0];
        rem       = negR ? -stepNext[DW-1:WIDTH] : stepNext[DW-1:WIDTH];
        mulResult = product;
        case (opReg)
            OP_MADD: mulResult = hiLo + product;
            OP_MSUB: mulResult = hiLo - product;
            default: mulResult = product;
        endcase
        if (runDiv) begin
            finalLo = bZero ? {WIDTH{1'b1}} : quot;
            finalHi = bZero ? aReg : rem;
        end else begin
            finalHi = mulResult[DW-1:WIDTH];
            finalLo = mulResult[WIDTH-1:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            count     <= '0;
            opReg     <= '0;
            aReg      <= '0;
            operand   <= '0;
            accum     <= '0;
            negQ      <= 1'b0;
            negR      <= 1'b0;
            bZero     <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            HI        <= '0;
            LO        <= '0;
        end else begin
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        case (Op)
                            OP_MTHI: begin
                                HI   <= A;
                                Done <= 1'b1;
                            end
                            OP_MTLO: begin
                                LO   <= A;
                                Done <= 1'b1;
                            end
                            default: begin
                                opReg <= Op;
                                aReg  <= A;
                                bZero <= (B == '0);
                                negQ  <= aNeg ^ bNeg;
                                negR  <= divOp && aNeg;
                                count <= '0;
                                Busy  <= 1'b1;
                                state <= RUN;
                                if (divOp) begin
                                    accum   <= {WIDTH'(0), absA};
                                    operand <= absB;
                                end else begin
                                    accum   <= {WIDTH'(0), absB};
                                    operand <= absA;
                                end
                            end
                        endcase
                    end
                end
                RUN: begin
                    accum <= stepNext;
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        HI        <= finalHi;
                        LO        <= finalLo;
                        Done      <= 1'b1;
                        DivByZero <= runDiv && bZero;
                        Busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit at WIDTH=32 with hand-computed results.
module tb_mult_div_unit;

    localparam int unsigned W = 32;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [2:0]   Op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Busy;
    logic         Done;
    logic         DivByZero;
    logic [W-1:0] HI;
    logic [W-1:0] LO;

    int total = 0;
    int bad   = 0;
    int lat;
    int busyN;
    int doneN;

    mult_div_unit #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .HI(HI), .LO(LO)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge, then scramble inputs to prove they were captured
    task automatic doOp(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        Start = 1'b1;
        Op    = o;
        A     = a;
        B     = b;
        tick();
        Start = 1'b0;
        Op    = 3'b011;
        A     = 32'hA5A5_5A5A;
        B     = 32'h0000_0000;
    endtask

    task automatic waitDone(output int l, output int bn);
        l  = 0;
        bn = 0;
        while (Done !== 1'b1 && l < 100) begin
            if (Busy === 1'b1) bn++;
            tick();
            l++;
        end
    endtask

    task automatic checkMulti(input string tag, input int expLat, input logic [W-1:0] expHi,
                              input logic [W-1:0] expLo, input logic expDbz);
        waitDone(lat, busyN);
        check({tag, "_lat"}, 64'(lat), 64'(expLat));
        check({tag, "_done"}, 64'(Done), 64'd1);
        check({tag, "_busy0"}, 64'(Busy), 64'd0);
        check({tag, "_hi"}, 64'(HI), 64'(expHi));
        check({tag, "_lo"}, 64'(LO), 64'(expLo));
        check({tag, "_dbz"}, 64'(DivByZero), 64'(expDbz));
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        Op    = 3'b000;
        A     = '0;
        B     = '0;
        tick();
        tick();
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_dbz", 64'(DivByZero), 64'd0);
        check("rst_hi", 64'(HI), 64'd0);
        check("rst_lo", 64'(LO), 64'd0);
        Reset = 1'b0;
        tick();

        // MULT -3 * 7 = -21
        doOp(3'b000, 32'hFFFF_FFFD, 32'd7);
        check("mult_busy1", 64'(Busy), 64'd1);
        checkMulti("mult", 32, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        check("mult_busycnt", 64'(busyN), 64'd32);
        tick();
        check("mult_pulse", 64'(Done), 64'd0);
        check("mult_hold", 64'(LO), 64'hFFFF_FFEB);

        doOp(3'b011, 32'd100, 32'd7);
        checkMulti("divu", 32, 32'd2, 32'd14, 1'b0);
        doOp(3'b010, 32'hFFFF_FFF9, 32'd2);
        checkMulti("div_neg", 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        doOp(3'b010, 32'd5, 32'd0);
        checkMulti("div_zero", 32, 32'd5, 32'hFFFF_FFFF, 1'b1);
        tick();
        check("div_zero_clr", 64'(DivByZero), 64'd0);
        doOp(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        checkMulti("div_ovf", 32, 32'd0, 32'h8000_0000, 1'b0);
        doOp(3'b011, 32'h1234_5678, 32'd0);
        checkMulti("divu_zero", 32, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        doOp(3'b010, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        checkMulti("div_nn", 32, 32'hFFFF_FFFF, 32'd3, 1'b0);
        doOp(3'b000, 32'h8000_0000, 32'h8000_0000);
        checkMulti("mult_minmin", 32, 32'h4000_0000, 32'd0, 1'b0);
        doOp(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkMulti("multu_max", 32, 32'hFFFF_FFFE, 32'd1, 1'b0);

        // MTHI / MTLO complete without Busy
        doOp(3'b110, 32'd0, 32'd99);
        check("mthi_done", 64'(Done), 64'd1);
        check("mthi_busy", 64'(Busy), 64'd0);
        check("mthi_hi", 64'(HI), 64'd0);
        check("mthi_lo_hold", 64'(LO), 64'd1);
        tick();
        check("mthi_pulse", 64'(Done), 64'd0);
        doOp(3'b111, 32'd10, 32'd0);
        check("mtlo_done", 64'(Done), 64'd1);
        check("mtlo_lo", 64'(LO), 64'd10);
        check("mtlo_hi_hold", 64'(HI), 64'd0);
        tick();

        doOp(3'b100, 32'd3, 32'd4);
        checkMulti("madd", 32, 32'd0, 32'd22, 1'b0);
        doOp(3'b101, 32'd5, 32'd5);
        checkMulti("msub", 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        doOp(3'b100, 32'hFFFF_FFFE, 32'd3);
        checkMulti("madd_neg", 32, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b0);

        // Start while busy is ignored; Start in the Done cycle is accepted
        doOp(3'b001, 32'd2, 32'd3);
        repeat (8) tick();
        Start = 1'b1;
        Op    = 3'b011;
        B     = 32'd0;
        tick();
        Start = 1'b0;
        checkMulti("busy_ign", 23, 32'd0, 32'd6, 1'b0);
        doOp(3'b011, 32'd100, 32'd7);
        check("b2b_no_done", 64'(Done), 64'd0);
        check("b2b_busy", 64'(Busy), 64'd1);
        checkMulti("b2b", 32, 32'd2, 32'd14, 1'b0);
        tick();

        // Reset mid-operation aborts with cleared HI/LO and no Done
        doOp(3'b000, 32'hFFFF_FFFD, 32'd7);
        repeat (14) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_done", 64'(Done), 64'd0);
        check("abort_hi", 64'(HI), 64'd0);
        check("abort_lo", 64'(LO), 64'd0);
        doneN = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done === 1'b1) doneN++;
            tick();
        end
        check("abort_nodone", 64'(doneN), 64'd0);

        doOp(3'b011, 32'd9, 32'd4);
        checkMulti("post_rst", 32, 32'd1, 32'd2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
